trdb_packet_decoder: RTL and testbench

- Decoder-side counterpart of the trace encoder's packet format selector. It receives the framed byte stream produced by the packet emitter/serialiser, reassembles one trace packet at a time, and extracts the packet format and sync subformat.
- It hands a parsed packet descriptor downstream over a valid/ready handshake.
- It sits between the trace sink byte interface and the software-model-compatible trace decoder/checker.

---
 rtl/trdb_packet_decoder_if.sv | 32 +++
 rtl/trdb_packet_decoder.sv | 150 +++++++++++++++
 tb/tb_trdb_packet_decoder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/trdb_packet_decoder_if.sv
// Byte-stream in / parsed-packet out bundle for the trace packet decoder.
// slave = decoder side, master = byte source plus packet sink side.
interface trdb_packet_decoder_if #(
    parameter int MAX_PKT_BYTES = 16,
    parameter int PAYLOAD_W     = MAX_PKT_BYTES * 8,
    parameter int CNT_W         = 16
);
    logic                 flush_i;
    logic                 byte_valid_i;
    logic [7:0]           byte_i;
    logic                 byte_ready_o;
    logic                 pkt_valid_o;
    logic                 pkt_ready_i;
    logic [1:0]           format_o;
    logic [1:0]           subformat_o;
    logic [4:0]           length_o;
    logic [PAYLOAD_W-1:0] payload_o;
    logic                 err_o;
    logic [CNT_W-1:0]     pkt_count_o;

    modport slave (
        input  flush_i, byte_valid_i, byte_i, pkt_ready_i,
        output byte_ready_o, pkt_valid_o, format_o, subformat_o,
               length_o, payload_o, err_o, pkt_count_o
    );

    modport master (
        output flush_i, byte_valid_i, byte_i, pkt_ready_i,
        input  byte_ready_o, pkt_valid_o, format_o, subformat_o,
               length_o, payload_o, err_o, pkt_count_o
    );
endinterface

// File: rtl/trdb_packet_decoder.sv
// Reassembles header+payload trace packets and emits format/subformat/payload.
// Packet valid one cycle after its last byte; bytes stall (ready=0) while a packet waits downstream.
module trdb_packet_decoder #(
    parameter int MAX_PKT_BYTES = 16,
    parameter int PAYLOAD_W     = MAX_PKT_BYTES * 8,
    parameter int CNT_W         = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    trdb_packet_decoder_if.slave   bus
);
    typedef enum logic [1:0] {
        F_OPT_EXT    = 2'd0,
        F_DIFF_DELTA = 2'd1,
        F_ADDR_ONLY  = 2'd2,
        F_SYNC       = 2'd3
    } trdb_format_e;

    typedef enum logic [1:0] {
        SF_START   = 2'd0,
        SF_TRAP    = 2'd1,
        SF_CONTEXT = 2'd2,
        SF_SUPPORT = 2'd3
    } trdb_f_sync_subformat_e;

    typedef enum logic [1:0] {
        S_HDR     = 2'd0,
        S_PAYLOAD = 2'd1,
        S_OUT     = 2'd2
    } state_e;

    localparam logic [4:0]       MAX_L   = 5'(MAX_PKT_BYTES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [4:0]             r_len;
    logic [4:0]             r_idx;
    logic [PAYLOAD_W-1:0]   r_payload;
    trdb_format_e           r_format;
    trdb_f_sync_subformat_e r_subformat;
    logic [4:0]             r_length;
    logic                   r_err;
    logic [CNT_W-1:0]       r_pkt_count;

    logic                   w_byte_ready;
    logic                   w_pkt_valid;
    logic                   w_hdr_ok;
    logic                   w_last_byte;
    logic [3:0]             w_byte0;

    assign w_hdr_ok    = (bus.byte_i[7:5] == 3'b000) &&
                         (bus.byte_i[4:0] != 5'd0) &&
                         (bus.byte_i[4:0] <= MAX_L);
    assign w_last_byte = (r_idx == r_len - 5'd1);
    // For a one-byte packet the format byte is still on the bus, not yet in r_payload.
    assign w_byte0     = (r_idx == 5'd0) ? bus.byte_i[3:0] : r_payload[3:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_HDR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.flush_i) begin
            w_state_nxt = S_HDR;
        end else begin
            case (r_state)
                S_HDR:     if (bus.byte_valid_i && w_hdr_ok) w_state_nxt = S_PAYLOAD;
                S_PAYLOAD: if (bus.byte_valid_i && w_last_byte) w_state_nxt = S_OUT;
                S_OUT:     if (bus.pkt_ready_i) w_state_nxt = S_HDR;
                default:   w_state_nxt = S_HDR;
            endcase
        end
    end

    always_comb begin
        w_byte_ready = 1'b0;
        w_pkt_valid  = 1'b0;
        case (r_state)
            S_HDR:     w_byte_ready = 1'b1;
            S_PAYLOAD: w_byte_ready = 1'b1;
            S_OUT:     w_pkt_valid  = 1'b1;
            default:   w_byte_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_len       <= 5'd0;
            r_idx       <= 5'd0;
            r_payload   <= '0;
            r_format    <= F_OPT_EXT;
            r_subformat <= SF_START;
            r_length    <= 5'd0;
            r_err       <= 1'b0;
            r_pkt_count <= '0;
        end else begin
            r_err <= 1'b0;
            if (!bus.flush_i) begin
                case (r_state)
                    S_HDR: begin
                        if (bus.byte_valid_i) begin
                            if (w_hdr_ok) begin
                                r_len     <= bus.byte_i[4:0];
                                r_idx     <= 5'd0;
                                r_payload <= '0;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        if (bus.byte_valid_i) begin
                            for (int i = 0; i < MAX_PKT_BYTES; i++) begin
                                if (r_idx == 5'(i)) r_payload[i*8 +: 8] <= bus.byte_i;
                            end
                            r_idx <= r_idx + 5'd1;
                            if (w_last_byte) begin
                                r_format    <= trdb_format_e'(w_byte0[1:0]);
                                r_subformat <= (w_byte0[1:0] == F_SYNC) ?
                                               trdb_f_sync_subformat_e'(w_byte0[3:2]) : SF_START;
                                r_length    <= r_len;
                            end
                        end
                    end
                    S_OUT: begin
                        if (bus.pkt_ready_i && (r_pkt_count != CNT_MAX)) begin
                            r_pkt_count <= r_pkt_count + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.byte_ready_o = w_byte_ready;
    assign bus.pkt_valid_o  = w_pkt_valid;
    assign bus.format_o     = r_format;
    assign bus.subformat_o  = r_subformat;
    assign bus.length_o     = r_length;
    assign bus.payload_o    = r_payload;
    assign bus.err_o        = r_err;
    assign bus.pkt_count_o  = r_pkt_count;
endmodule

// File: tb/tb_trdb_packet_decoder.sv
// Bench for the trace packet decoder: vector table, hand-written corner sequences and random packets.
module tb_trdb_packet_decoder;
    localparam int MAXB  = 16;
    localparam int PW    = MAXB * 8;
    localparam int CNT_W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    trdb_packet_decoder_if #(.MAX_PKT_BYTES(MAXB), .PAYLOAD_W(PW), .CNT_W(CNT_W)) bus ();

    trdb_packet_decoder #(.MAX_PKT_BYTES(MAXB), .PAYLOAD_W(PW), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0]    hdr;
        logic [PW-1:0] pl;
        logic          exp_err;
        logic [1:0]    exp_fmt;
        logic [1:0]    exp_sub;
    } vec_t;

    vec_t vt[10];
    int   checks    = 0;
    int   errors    = 0;
    int   exp_count = 0;

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge that follows acceptance.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.byte_valid_i = 1'b1;
        bus.byte_i       = b;
        while (!bus.byte_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("byte_accept_timeout", 0, 1);
        @(negedge clk);
    endtask

    // Reference decode straight from the framing rules: format from byte 0, subformat only for sync.
    task automatic expect_pkt(input string tag, input int len, input logic [PW-1:0] pl, input int hold);
        int b0, fmt, sub;
        b0  = int'(pl[7:0]);
        fmt = b0 % 4;
        sub = (fmt == 3) ? (b0 / 4) % 4 : 0;
        bus.byte_valid_i = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            if (h == hold) bus.pkt_ready_i = 1'b1;
            chk({tag, "_valid"}, bus.pkt_valid_o, 1);
            chk({tag, "_fmt"}, bus.format_o, fmt[1:0]);
            chk({tag, "_sub"}, bus.subformat_o, sub[1:0]);
            chk({tag, "_len"}, bus.length_o, len[4:0]);
            chk({tag, "_payload"}, bus.payload_o, pl);
            chk({tag, "_byte_ready"}, bus.byte_ready_o, 0);
            if (h < hold) @(negedge clk);
        end
        @(negedge clk);
        exp_count++;
        chk({tag, "_count"}, bus.pkt_count_o, exp_count);
        chk({tag, "_valid_drop"}, bus.pkt_valid_o, 0);
    endtask

    task automatic expect_err(input string tag);
        bus.byte_valid_i = 1'b0;
        chk({tag, "_err_pulse"}, bus.err_o, 1);
        chk({tag, "_no_pkt"}, bus.pkt_valid_o, 0);
        @(negedge clk);
        chk({tag, "_err_clear"}, bus.err_o, 0);
        chk({tag, "_no_pkt2"}, bus.pkt_valid_o, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [PW-1:0] pl;
        int len, hold;
        logic [7:0] hdr, b;

        bus.flush_i      = 1'b0;
        bus.byte_valid_i = 1'b0;
        bus.byte_i       = 8'h00;
        bus.pkt_ready_i  = 1'b1;

        vt[0] = '{8'h03, 128'h3412A7, 1'b0, 2'd3, 2'd1};
        vt[1] = '{8'h02, 128'hFF05, 1'b0, 2'd1, 2'd0};
        vt[2] = '{8'h01, 128'h0E, 1'b0, 2'd2, 2'd0};
        vt[3] = '{8'h00, 128'h0, 1'b1, 2'd0, 2'd0};
        vt[4] = '{8'h11, 128'h0, 1'b1, 2'd0, 2'd0};
        vt[5] = '{8'h21, 128'h0, 1'b1, 2'd0, 2'd0};
        vt[6] = '{8'h01, 128'h0F, 1'b0, 2'd3, 2'd3};
        vt[7] = '{8'h10, 128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0, 2'd0, 2'd0};
        vt[8] = '{8'h1F, 128'h0, 1'b1, 2'd0, 2'd0};
        vt[9] = '{8'hE1, 128'h0, 1'b1, 2'd0, 2'd0};

        #2;
        chk("rst_valid", bus.pkt_valid_o, 0);
        chk("rst_err", bus.err_o, 0);
        chk("rst_count", bus.pkt_count_o, 0);
        chk("rst_fmt", bus.format_o, 0);
        chk("rst_sub", bus.subformat_o, 0);
        chk("rst_len", bus.length_o, 0);
        chk("rst_payload", bus.payload_o, 0);
        chk("rst_byte_ready", bus.byte_ready_o, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            send_byte(vt[i].hdr);
            if (vt[i].exp_err) begin
                expect_err("vec");
            end else begin
                len = int'(vt[i].hdr[4:0]);
                for (int k = 0; k < len; k++) send_byte(vt[i].pl[k*8 +: 8]);
                bus.byte_valid_i = 1'b0;
                chk("vec_fmt_tbl", bus.format_o, vt[i].exp_fmt);
                chk("vec_sub_tbl", bus.subformat_o, vt[i].exp_sub);
                expect_pkt("vec", len, vt[i].pl, 0);
            end
        end

        // Backpressure with the next header already waiting on the bus.
        bus.pkt_ready_i = 1'b0;
        send_byte(8'h01);
        send_byte(8'h07);
        bus.byte_valid_i = 1'b1;
        bus.byte_i       = 8'h01;
        for (int h = 0; h < 5; h++) begin
            chk("bp_valid", bus.pkt_valid_o, 1);
            chk("bp_byte_ready", bus.byte_ready_o, 0);
            chk("bp_payload", bus.payload_o, 128'h07);
            chk("bp_fmt", bus.format_o, 3);
            chk("bp_sub", bus.subformat_o, 1);
            chk("bp_count_held", bus.pkt_count_o, exp_count);
            @(negedge clk);
        end
        bus.pkt_ready_i = 1'b1;
        send_byte(8'h01);
        exp_count++;
        chk("bp_count_once", bus.pkt_count_o, exp_count);
        send_byte(8'h0A);
        expect_pkt("bp_next", 1, 128'h0A, 0);

        // Flush mid-packet, with a byte presented in the flush cycle.
        send_byte(8'h03);
        send_byte(8'h33);
        bus.byte_valid_i = 1'b1;
        bus.byte_i       = 8'h44;
        bus.flush_i      = 1'b1;
        @(negedge clk);
        bus.flush_i      = 1'b0;
        bus.byte_valid_i = 1'b0;
        chk("flush_valid", bus.pkt_valid_o, 0);
        chk("flush_byte_ready", bus.byte_ready_o, 1);
        chk("flush_count", bus.pkt_count_o, exp_count);
        send_byte(8'h01);
        send_byte(8'h00);
        expect_pkt("post_flush", 1, 128'h00, 0);

        // Flush while the packet is offered and accepted in the same cycle.
        send_byte(8'h01);
        send_byte(8'h05);
        bus.byte_valid_i = 1'b0;
        bus.flush_i      = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        chk("flush_out_valid", bus.pkt_valid_o, 0);
        chk("flush_out_count", bus.pkt_count_o, exp_count);

        // Asynchronous reset while a packet is pending.
        bus.pkt_ready_i = 1'b0;
        send_byte(8'h02);
        send_byte(8'h13);
        send_byte(8'h57);
        bus.byte_valid_i = 1'b0;
        chk("pre_rst_valid", bus.pkt_valid_o, 1);
        #1 rst_n = 1'b0;
        #1;
        exp_count = 0;
        chk("mid_rst_valid", bus.pkt_valid_o, 0);
        chk("mid_rst_payload", bus.payload_o, 0);
        chk("mid_rst_fmt", bus.format_o, 0);
        chk("mid_rst_len", bus.length_o, 0);
        chk("mid_rst_count", bus.pkt_count_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.pkt_ready_i = 1'b1;
        chk("post_rst_byte_ready", bus.byte_ready_o, 1);
        send_byte(8'h02);
        send_byte(8'h13);
        send_byte(8'h57);
        expect_pkt("post_rst", 2, 128'h5713, 0);

        // Random packets, random downstream stalls, occasional malformed headers.
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 5) == 0) begin
                do begin
                    hdr = 8'($urandom_range(0, 255));
                end while ((hdr / 32) == 0 && (hdr % 32) >= 1 && (hdr % 32) <= MAXB);
                send_byte(hdr);
                expect_err("rnd");
            end else begin
                len  = $urandom_range(1, MAXB);
                hold = $urandom_range(0, 3);
                pl   = '0;
                bus.pkt_ready_i = (hold == 0);
                send_byte(8'(len));
                for (int k = 0; k < len; k++) begin
                    b = 8'($urandom_range(0, 255));
                    pl = pl | ({{(PW-8){1'b0}}, b} << (8 * k));
                    if ($urandom_range(0, 3) == 0) begin
                        bus.byte_valid_i = 1'b0;
                        @(negedge clk);
                    end
                    send_byte(b);
                end
                expect_pkt("rnd", len, pl, hold);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
